// File: rtl/cmp_pkg.sv
// Shared opcode/state types for the shared comparator arbiter.
// Pure types and helpers: no latency, no backpressure.
package cmp_pkg;

  localparam int CMP_WIDTH = 32;

  typedef enum logic [3:0] {
    CMP_SLT  = 4'b0101,
    CMP_SGT  = 4'b0110,
    CMP_SLTU = 4'b0111,
    CMP_SGTU = 4'b1000,
    CMP_EQ   = 4'b1001,
    CMP_NE   = 4'b1010
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } cmp_state_e;

  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op >= CMP_SLT) && (op <= CMP_NE);
  endfunction

endpackage

// File: rtl/comparator.sv
// 32-bit compare unit returning 0/1; signed forms use the sign qualifiers as a 33rd bit.
// Purely combinational, no backpressure; unknown opcodes give 0.
module comparator
  import cmp_pkg::*;
(
  input  logic [3:0]           i_opcode,
  input  logic [CMP_WIDTH-1:0] i_a,
  input  logic [CMP_WIDTH-1:0] i_b,
  input  logic                 i_a_sign,
  input  logic                 i_b_sign,
  output logic [CMP_WIDTH-1:0] o_result,
  output logic                 o_zero_flag
);

  logic signed [CMP_WIDTH:0] w_sa;
  logic signed [CMP_WIDTH:0] w_sb;
  logic                      w_hit;

  assign w_sa = {i_a_sign, i_a};
  assign w_sb = {i_b_sign, i_b};

  always_comb begin
    w_hit = 1'b0;
    case (i_opcode)
      CMP_SLT:  w_hit = (w_sa < w_sb);
      CMP_SGT:  w_hit = (w_sb < w_sa);
      CMP_SLTU: w_hit = (i_a < i_b);
      CMP_SGTU: w_hit = (i_b < i_a);
      CMP_EQ:   w_hit = (i_a == i_b);
      CMP_NE:   w_hit = (i_a != i_b);
      default:  w_hit = 1'b0;
    endcase
  end

  assign o_result    = {{(CMP_WIDTH-1){1'b0}}, w_hit};
  assign o_zero_flag = !w_hit;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or above i_ptr, wrapping modulo N.
// Combinational, no backpressure; grant is all-zero when nothing requests.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] w_j;

  // Walk from the farthest offset down so the closest requester to i_ptr wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_gnt_idx  = w_j;
      end
    end
  end

endmodule

// File: rtl/compare_arbiter.sv
// Shares one comparator among NUM_REQ requesters with round-robin accept, one compare in flight.
// Accept at T -> rsp_valid at T+2; response held until the owner's rsp_ready, no new accept until then.
module compare_arbiter
  import cmp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][3:0]         req_opcode,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]              req_a_sign,
  input  logic [NUM_REQ-1:0]              req_b_sign,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [WIDTH-1:0]                rsp_result,
  output logic                            rsp_zero,
  output logic                            rsp_illegal
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  cmp_state_e         r_state;
  cmp_state_e         w_state_nxt;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [3:0]         r_opcode;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_a_sign;
  logic               r_b_sign;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;
  logic [WIDTH-1:0]   w_cmp_result;
  logic               w_cmp_zero;
  logic               w_accept;
  logic               w_rsp_done;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  comparator u_cmp (
    .i_opcode    (r_opcode),
    .i_a         (r_a),
    .i_b         (r_b),
    .i_a_sign    (r_a_sign),
    .i_b_sign    (r_b_sign),
    .o_result    (w_cmp_result),
    .o_zero_flag (w_cmp_zero)
  );

  // Grant only depends on state and req_valid, never on rsp_ready.
  assign req_ready   = (r_state == IDLE && !reset) ? w_gnt : '0;
  assign w_accept    = |(req_valid & req_ready);
  assign w_rsp_done  = (r_state == RESP) && rsp_ready[r_owner];
  assign rsp_valid   = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_illegal = r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = RESP;
      RESP:    if (w_rsp_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_opcode  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_a_sign  <= 1'b0;
      r_b_sign  <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opcode <= req_opcode[w_gnt_idx];
        r_a      <= req_a[w_gnt_idx];
        r_b      <= req_b[w_gnt_idx];
        r_a_sign <= req_a_sign[w_gnt_idx];
        r_b_sign <= req_b_sign[w_gnt_idx];
        r_owner  <= w_gnt_idx;
        r_rr_ptr <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
      end
      if (r_state == EVAL) begin
        r_result  <= w_cmp_result;
        r_zero    <= w_cmp_zero;
        r_illegal <= !is_cmp_op(r_opcode);
      end
    end
  end

endmodule
